stream_to_hs_adapter: RTL and testbench
=======================================

Name: stream_to_hs_adapter

Overview:
- Receive direction of the accelerator stream interface: takes AXI-Stream beats from the interconnect and presents them to an HLS accelerator's ap_hs input port (vld/ack handshake).
- Counterpart of the accelerator's ap_hs-to-stream output adapter; uses the same 68-bit packing (data, dest, last).
- Buffers beats in a small FIFO so the interconnect is not throttled by per-beat accelerator ack latency.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ACCID_WIDTH, 4, width of the tid field and of accID.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  synchronous reset, active low.
- accID  in  ACCID_WIDTH  this accelerator's ID; used only with the optional feature.
- inStream_tdata  in  64  beat payload.
- inStream_tdest  in  3  sub-port/beat type.
- inStream_tid  in  ACCID_WIDTH  source/target ID tag.
- inStream_tlast  in  1  last beat of packet.
- inStream_tvalid  in  1  beat valid.
- inStream_tready  out  1  beat accepted when tvalid && tready.
- out_hs  out  68  packed beat: [0] tlast, [3:1] tdest, [67:4] tdata.
- out_hs_ap_vld  out  1  out_hs holds a valid beat.
- out_hs_ap_ack  in  1  accelerator consumed out_hs.

Behaviour:
- Storage: DEPTH x 68-bit array; write pointer, read pointer and occupancy count (log2(DEPTH)+1 bits). Pointers wrap modulo DEPTH.
- Push: when inStream_tvalid && inStream_tready, write {tdata, tdest, tlast} at the write pointer.
- Pop: when out_hs_ap_vld && out_hs_ap_ack, advance the read pointer.
  - out_hs_ap_ack while out_hs_ap_vld=0 is ignored; no state change.
- Outputs:
  - out_hs_ap_vld = (count != 0).
  - out_hs = entry at the read pointer (asynchronous read). It is stable while vld=1 and no ack.
- inStream_tready is registered: next value = (count_next < DEPTH), where count_next = count + push - pop.
  - Full: no push possible, so count never exceeds DEPTH.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - At count == DEPTH-1, push+pop keeps tready=1.
  - At count == DEPTH-1, push only drops tready in the next cycle.
  - At count == DEPTH, pop only raises tready in the next cycle.
- Latency: a beat accepted at edge N drives out_hs_ap_vld=1 from cycle N+1 (FIFO empty case). Minimum in-to-out latency is 1 cycle.
- Throughput: 1 beat/cycle sustained when the accelerator acks every cycle.
- Ordering: strict FIFO. tlast is passed through; packets are never reordered or merged.
- Reset (aresetn=0 at an edge):
  - Pointers and count cleared; inStream_tready=0; out_hs_ap_vld=0.
  - Stored beats are discarded, including when reset hits mid-packet.
  - out_hs contents are don't-care while vld=0.
  - First cycle after reset release: tready=1.
- Beats presented while tready=0 must be held by the source (AXI rule); they are not sampled.

Optional Feature:
- Macro: STREAM_TO_HS_ACCID_FILTER_EN.
- Defined:
  - A beat with inStream_tid != accID is accepted (tready honoured) but not written to the FIFO.
  - Filtering applies per beat and covers all beats of a foreign packet, including its tlast beat.
  - The count is unchanged for a dropped beat; tready logic treats it as no push.
- Not defined: accID and inStream_tid are unused; every accepted beat is stored.

Test Plan:
- Single beat: after reset, send tdata=0x0123456789ABCDEF, tdest=3, tlast=1 with ack held 0 -> next cycle out_hs_ap_vld=1, out_hs=0x0123456789ABCDEF_7 (low nibble 0b0111). out_hs is stable until ack; vld=0 the cycle after ack.
- Fill (DEPTH=4): push 4 beats 1..4, no ack -> tready=0 from the cycle after the 4th push. A 5th beat held on the bus is not taken. One ack pops data=1 and tready=1 next cycle; the 5th beat is then accepted. Output order is 1,2,3,4,5.
- Streaming: tvalid=1 and ack=1 continuously for 16 beats 0..15 -> tready never drops, out_hs data 0..15 one per cycle, 1-cycle latency.
- Simultaneous: at count=3, push+pop in the same cycle -> count stays 3, tready stays 1. Pointer wrap past index 3 preserves order.
- Reset mid-packet: 2 beats stored, assert aresetn=0 for 1 cycle -> vld=0 and tready=0 during reset. After release, tready=1, FIFO empty, and old beats never appear.
- Filter (macro on, accID=5): send beats with tid=5, 2, 5 -> all accepted; out_hs presents only the two tid=5 beats.

Source files
------------

// File: rtl/stream_to_hs_adapter.sv
// AXI-Stream beats in, ap_hs vld/ack beats out, through a DEPTH-entry FIFO; optional STREAM_TO_HS_ACCID_FILTER_EN drops beats with a foreign tid.
// Latency: 1 cycle from acceptance to out_hs_ap_vld; 1 beat/cycle sustained.
// Backpressure: registered inStream_tready falls once the FIFO is full and rises the cycle after a pop.
module stream_to_hs_adapter #(
  parameter int DEPTH       = 4,
  parameter int ACCID_WIDTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [ACCID_WIDTH-1:0] accID,
  input  logic [63:0]            inStream_tdata,
  input  logic [2:0]             inStream_tdest,
  input  logic [ACCID_WIDTH-1:0] inStream_tid,
  input  logic                   inStream_tlast,
  input  logic                   inStream_tvalid,
  output logic                   inStream_tready,
  output logic [67:0]            out_hs,
  output logic                   out_hs_ap_vld,
  input  logic                   out_hs_ap_ack
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [67:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             accept;
  logic             push;
  logic             pop;

  assign accept = inStream_tvalid && inStream_tready;

`ifdef STREAM_TO_HS_ACCID_FILTER_EN
  // Foreign beats are still handshaken so the interconnect drains them.
  assign push = accept && (inStream_tid == accID);
`else
  logic unused_id;
  assign unused_id = ^{accID, inStream_tid};
  assign push = accept;
`endif

  assign pop           = out_hs_ap_vld && out_hs_ap_ack;
  assign count_next    = count + CNT_W'(push) - CNT_W'(pop);
  assign out_hs_ap_vld = (count != '0);
  assign out_hs        = mem[rd_ptr];

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      inStream_tready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count           <= count_next;
      inStream_tready <= (count_next < CNT_W'(DEPTH));
    end
  end

  // Storage needs no reset: contents are only observed while count != 0.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= {inStream_tdata, inStream_tdest, inStream_tlast};
  end

endmodule

// File: tb/tb_stream_to_hs_adapter.sv
// Randomized and directed checks of stream_to_hs_adapter against a queue-based reference model.
module tb_stream_to_hs_adapter;
  localparam int DEPTH  = 4;
  localparam int AW     = 4;
  localparam logic [AW-1:0] ACC_ID = 4'd5;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] accID;
  logic [63:0]   tdata;
  logic [2:0]    tdest;
  logic [AW-1:0] tid;
  logic          tlast;
  logic          tvalid;
  logic          tready;
  logic [67:0]   out_hs;
  logic          vld;
  logic          ack;

  int n_cmp = 0;
  int n_err = 0;

  logic [67:0] mq[$];
  bit          m_rdy;
  bit          last_acc;

  always #5 aclk = ~aclk;

  stream_to_hs_adapter #(.DEPTH(DEPTH), .ACCID_WIDTH(AW)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .accID           (accID),
    .inStream_tdata  (tdata),
    .inStream_tdest  (tdest),
    .inStream_tid    (tid),
    .inStream_tlast  (tlast),
    .inStream_tvalid (tvalid),
    .inStream_tready (tready),
    .out_hs          (out_hs),
    .out_hs_ap_vld   (vld),
    .out_hs_ap_ack   (ack)
  );

  task automatic chk_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check outputs at the falling edge, then advance the model.
  task automatic step(input bit v, input logic [63:0] d, input logic [2:0] de, input bit l,
                      input logic [AW-1:0] id, input bit a);
    bit acc, pp, keep;
    tvalid = v; tdata = d; tdest = de; tlast = l; tid = id; ack = a;
    @(negedge aclk);
    chk_eq("tready", {67'd0, tready}, {67'd0, m_rdy});
    chk_eq("vld", {67'd0, vld}, {67'd0, mq.size() != 0});
    if (mq.size() != 0) chk_eq("out_hs", out_hs, mq[0]);
    acc = v && m_rdy;
    pp  = a && (mq.size() != 0);
`ifdef STREAM_TO_HS_ACCID_FILTER_EN
    keep = (id == ACC_ID);
`else
    keep = 1'b1;
`endif
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      mq.delete();
      m_rdy = 1'b0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc && keep) mq.push_back({d, de, l});
      m_rdy = (mq.size() < DEPTH);
    end
    last_acc = acc;
  endtask

  task automatic idle(input bit a, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 3'd0, 1'b0, ACC_ID, a);
  endtask

  // Presents a beat until it is taken, bounded so a stuck tready still ends the run.
  task automatic send(input logic [63:0] d, input logic [2:0] de, input bit l,
                      input logic [AW-1:0] id, input bit a);
    int guard = 0;
    do begin
      step(1'b1, d, de, l, id, a);
      guard++;
    end while (!last_acc && guard < 20);
    chk_eq("send_taken", {67'd0, last_acc}, 68'd1);
  endtask

  initial begin
    bit          pend;
    logic [63:0] pd;
    logic [2:0]  pde;
    bit          pl;
    logic [AW-1:0] pid;

    accID = ACC_ID; aresetn = 1'b0;
    tvalid = 0; tdata = 0; tdest = 0; tid = 0; tlast = 0; ack = 0;
    m_rdy = 1'b0; last_acc = 1'b0;
    @(posedge aclk); #1;
    idle(1'b0, 2);
    aresetn = 1'b1;
    idle(1'b0, 1);
    chk_eq("rst_rel_tready", {67'd0, tready}, 68'd1);

    // Single beat held without ack
    send(64'h0123456789ABCDEF, 3'd3, 1'b1, ACC_ID, 1'b0);
    chk_eq("single_hs", out_hs, 68'h0123456789ABCDEF7);
    idle(1'b0, 2);
    chk_eq("single_hold", out_hs, 68'h0123456789ABCDEF7);
    idle(1'b1, 1);
    idle(1'b0, 1);
    chk_eq("single_vld_after_ack", {67'd0, vld}, 68'd0);

    // Fill, 5th beat held off until a pop frees a slot
    for (int i = 1; i <= 4; i++) send(64'(i), 3'd0, 1'b0, ACC_ID, 1'b0);
    step(1'b1, 64'd5, 3'd0, 1'b1, ACC_ID, 1'b0);
    chk_eq("full_not_taken", {67'd0, last_acc}, 68'd0);
    chk_eq("full_tready", {67'd0, tready}, 68'd0);
    step(1'b1, 64'd5, 3'd0, 1'b1, ACC_ID, 1'b1);
    chk_eq("pop_raises_tready", {67'd0, tready}, 68'd1);
    send(64'd5, 3'd0, 1'b1, ACC_ID, 1'b0);
    idle(1'b1, 5);

    // Streaming with continuous ack
    for (int i = 0; i < 16; i++) step(1'b1, 64'(i), 3'd1, i == 15, ACC_ID, 1'b1);
    idle(1'b1, 2);

    // Push+pop at DEPTH-1, then wrap the pointers
    for (int i = 0; i < 3; i++) send(64'(100 + i), 3'd2, 1'b0, ACC_ID, 1'b0);
    step(1'b1, 64'd103, 3'd2, 1'b0, ACC_ID, 1'b1);
    chk_eq("simul_tready", {67'd0, tready}, 68'd1);
    for (int i = 4; i < 10; i++) step(1'b1, 64'(100 + i), 3'd2, 1'b0, ACC_ID, 1'b1);
    idle(1'b1, 5);

    // Reset mid-packet
    send(64'hAA, 3'd4, 1'b0, ACC_ID, 1'b0);
    send(64'hBB, 3'd4, 1'b0, ACC_ID, 1'b0);
    aresetn = 1'b0;
    idle(1'b0, 1);
    chk_eq("rst_vld", {67'd0, vld}, 68'd0);
    chk_eq("rst_tready", {67'd0, tready}, 68'd0);
    aresetn = 1'b1;
    idle(1'b0, 1);
    send(64'hCC, 3'd5, 1'b1, ACC_ID, 1'b0);
    chk_eq("rst_no_stale", out_hs, {64'hCC, 3'd5, 1'b1});
    idle(1'b1, 2);

    // Foreign tid in the middle of local traffic
    send(64'hA1, 3'd0, 1'b0, ACC_ID, 1'b0);
    send(64'hB2, 3'd0, 1'b1, 4'd2, 1'b0);
    send(64'hC3, 3'd0, 1'b1, ACC_ID, 1'b0);
    idle(1'b1, 4);

    // Randomized traffic with held beats and occasional reset
    pend = 1'b0; pd = '0; pde = '0; pl = 1'b0; pid = '0;
    for (int c = 0; c < 2000; c++) begin
      aresetn = ($urandom_range(249) != 0);
      if (!pend && $urandom_range(9) < 7) begin
        pend = 1'b1;
        pd   = {$urandom, $urandom};
        pde  = 3'($urandom);
        pl   = 1'($urandom);
        pid  = ($urandom_range(3) == 0) ? AW'($urandom) : ACC_ID;
      end
      step(pend, pd, pde, pl, pid, $urandom_range(1) == 1);
      if (last_acc || !aresetn) pend = 1'b0;
    end
    aresetn = 1'b1;
    idle(1'b1, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
